// File: rtl/toaster_pkg.sv
// Shared types and limits for the toaster countdown timer.
// Holds the FSM state enum, range limits and the load clamp helpers.
package toaster_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAX_SECONDS = 599;
    localparam int MAX_DUTY    = 100;
    localparam int PWM_STEPS   = 100;

    localparam int SEC_W = 10;
    localparam int BCD_W = 12;

    function automatic logic [SEC_W-1:0] clamp_secs(
        input logic [SEC_W-1:0] t
    );
        if (t > SEC_W'(MAX_SECONDS))
            return SEC_W'(MAX_SECONDS);
        return t;
    endfunction

    function automatic logic [6:0] clamp_duty(input logic [7:0] d);
        if (d > 8'(MAX_DUTY))
            return 7'(MAX_DUTY);
        return d[6:0];
    endfunction

endpackage

// File: rtl/toast_timer_sec2bcd.sv
// Combinational seconds (0..599) to m:ss BCD converter.
// Ports: secs in (10 bit binary), bcd out {minutes, tens, ones}.
module sec2bcd
    import toaster_pkg::*;
(
    input  logic [SEC_W-1:0] secs,
    output logic [BCD_W-1:0] bcd
);

    logic [3:0]       mins;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic [SEC_W-1:0] rest;

    // Threshold compares instead of dividers: the input range is
    // small, so a short priority chain is cheap and fast.
    always_comb begin
        mins = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (secs >= SEC_W'(k * 60))
                mins = 4'(k);
        end
        rest = secs - SEC_W'({6'd0, mins} * 10'd60);
        tens = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            if (rest >= SEC_W'(k * 10))
                tens = 4'(k);
        end
        ones = 4'(rest - SEC_W'({6'd0, tens} * 10'd10));
        bcd  = {mins, tens, ones};
    end

endmodule

// File: rtl/toast_timer.sv
// Toaster countdown timer with PWM heater drive and BCD display.
// Ports: clk, reset (sync, active-high); Time/DC/write load bus with
// write_ack 4-phase handshake; start/stop run control (stop wins);
// tLED BCD remaining time, heat PWM output, done pulse, busy in RUN.
module toast_timer
    import toaster_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int PWM_DIV = 5000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEC_W-1:0] Time,
    input  logic [7:0]       DC,
    input  logic             start,
    input  logic             stop,
    input  logic             write,
    output logic             write_ack,
    output logic [BCD_W-1:0] tLED,
    output logic             heat,
    output logic             done,
    output logic             busy
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DIV_MAX  = DW'(PWM_DIV - 1);
    localparam logic [6:0]    STEP_MAX = 7'(PWM_STEPS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [SEC_W-1:0] rem_s;
    logic [6:0]       duty;
    logic [PW-1:0]    presc;
    logic [DW-1:0]    div;
    logic [6:0]       step;
    logic [BCD_W-1:0] bcd;

    logic load;
    logic wrap;
    logic run_ok;
    logic sec_tick;
    logic expire;

    // A new load is only taken on the rising half of the handshake.
    assign load   = write & ~write_ack;
    assign wrap   = (presc == PRE_MAX);
    assign run_ok = start & ~stop & (rem_s != '0);

    // A second elapses only when running undisturbed; a load in the
    // same cycle wins and restarts the second instead.
    assign sec_tick = (state == RUN) & ~stop & ~load & wrap;
    assign expire   = sec_tick & (rem_s <= SEC_W'(1));

    sec2bcd u_bcd (
        .secs (rem_s),
        .bcd  (bcd)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (run_ok)
                    state_nxt = RUN;
            end
            RUN: begin
                if (stop)
                    state_nxt = PAUSE;
                else if (expire)
                    state_nxt = DONE;
            end
            PAUSE: begin
                if (run_ok)
                    state_nxt = RUN;
            end
            DONE: begin
                if (stop || load)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_ack <= 1'b0;
            rem_s     <= '0;
            duty      <= '0;
            presc     <= '0;
        end else begin
            write_ack <= write;
            if (load) begin
                rem_s <= clamp_secs(Time);
                duty  <= clamp_duty(DC);
                presc <= '0;
            end else if (state == RUN && !stop) begin
                if (wrap) begin
                    presc <= '0;
                    if (rem_s != '0)
                        rem_s <= rem_s - SEC_W'(1);
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // Free-running PWM phase, independent of the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            div  <= '0;
            step <= '0;
        end else if (div == DIV_MAX) begin
            div  <= '0;
            step <= (step == STEP_MAX) ? 7'd0 : step + 7'd1;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tLED <= '0;
            heat <= 1'b0;
            done <= 1'b0;
        end else begin
            tLED <= bcd;
            heat <= (state == RUN) && (step < duty);
            done <= expire;
        end
    end

endmodule

// File: tb/tb_toast_timer.sv
// Randomized self-checking bench for toast_timer against a
// cycle-level behavioural reference model.
module tb_toast_timer;

    localparam int CLK_HZ  = 10;
    localparam int PWM_DIV = 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] Time  = '0;
    logic [7:0] DC    = '0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       write = 1'b0;

    logic        write_ack;
    logic [11:0] tLED;
    logic        heat;
    logic        done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    int m_st;
    int m_rem;
    int m_duty;
    int m_pre;
    int m_cyc;
    int m_ack;
    logic [11:0] e_tled;
    logic        e_heat;
    logic        e_done;

    toast_timer #(
        .CLK_HZ  (CLK_HZ),
        .PWM_DIV (PWM_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Time      (Time),
        .DC        (DC),
        .start     (start),
        .stop      (stop),
        .write     (write),
        .write_ack (write_ack),
        .tLED      (tLED),
        .heat      (heat),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int s);
        int m;
        int r;
        m = s / 60;
        r = s % 60;
        return {4'(m), 4'(r / 10), 4'(r % 10)};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step();
        int ld;
        int stp;
        int nst;
        int nrem;
        int npre;
        int nduty;
        if (reset) begin
            m_st   = M_IDLE;
            m_rem  = 0;
            m_duty = 0;
            m_pre  = 0;
            m_cyc  = 0;
            m_ack  = 0;
            e_tled = '0;
            e_heat = 1'b0;
            e_done = 1'b0;
        end else begin
            stp    = (m_cyc / PWM_DIV) % 100;
            ld     = (write && m_ack == 0) ? 1 : 0;
            e_heat = (m_st == M_RUN) && (stp < m_duty);
            e_tled = to_bcd(m_rem);
            e_done = 1'b0;
            nst    = m_st;
            nrem   = m_rem;
            npre   = m_pre;
            nduty  = m_duty;
            if (ld != 0) begin
                nrem  = imin(int'(Time), 599);
                nduty = imin(int'(DC), 100);
                npre  = 0;
            end
            case (m_st)
                M_IDLE, M_PAUSE: begin
                    if (start && !stop && m_rem > 0)
                        nst = M_RUN;
                end
                M_RUN: begin
                    if (stop) begin
                        nst = M_PAUSE;
                    end else if (ld == 0) begin
                        if (m_pre == CLK_HZ - 1) begin
                            npre = 0;
                            if (m_rem <= 1) begin
                                nrem   = 0;
                                nst    = M_DONE;
                                e_done = 1'b1;
                            end else begin
                                nrem = m_rem - 1;
                            end
                        end else begin
                            npre = m_pre + 1;
                        end
                    end
                end
                default: begin
                    if (stop || ld != 0)
                        nst = M_IDLE;
                end
            endcase
            m_st   = nst;
            m_rem  = nrem;
            m_pre  = npre;
            m_duty = nduty;
            m_ack  = write ? 1 : 0;
            m_cyc++;
        end
    endtask

    task automatic tick();
        logic [15:0] exp;
        @(posedge clk);
        model_step();
        #1;
        exp = {m_ack[0], e_tled, e_heat, e_done, m_st == M_RUN};
        chk("outs", {16'd0, write_ack, tLED, heat, done, busy},
            {16'd0, exp});
    endtask

    task automatic load(input int t, input int d);
        Time  = 10'(t);
        DC    = 8'(d);
        write = 1'b1;
        tick();
        write = 1'b0;
        tick();
    endtask

    int cnt;
    int cnt2;
    int at;
    int found;

    initial begin
        reset = 1'b1;
        tick();
        tick();
        chk("reset", {write_ack, tLED, heat, done, busy}, 0);
        reset = 1'b0;
        tick();

        // load handshake
        Time  = 10'd75;
        DC    = 8'd50;
        write = 1'b1;
        tick();
        chk("ack_rise", write_ack, 1);
        tick();
        chk("tled_75", tLED, 12'h115);
        chk("ack_hold", write_ack, 1);
        write = 1'b0;
        tick();
        chk("ack_fall", write_ack, 0);

        // countdown to done
        load(3, 50);
        chk("tled_3", tLED, 12'h003);
        start = 1'b1;
        cnt   = 0;
        at    = -1;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (done) begin
                cnt++;
                at = i - 1;
            end
        end
        chk("done_cnt", cnt, 1);
        chk("done_lat", at, 30);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt += int'(heat) + int'(busy);
        end
        chk("stay_done", cnt, 0);
        chk("tled_0", tLED, 12'h000);
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // PWM at 25% then clamped 100%
        load(599, 25);
        start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cnt += int'(heat);
        end
        chk("pwm25", cnt, 25);
        load(599, 200);
        tick();
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cnt += int'(heat);
        end
        chk("pwm100", cnt, 100);

        // pause at 0:05 and resume
        load(8, 100);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (tLED == 12'h005)
                found = 1;
        end
        chk("saw005", found, 1);
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        cnt  = 0;
        cnt2 = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            cnt  += int'(heat);
            cnt2 += int'(tLED == 12'h005);
        end
        chk("pause_heat", cnt, 0);
        chk("pause_tled", cnt2, 50);
        start = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (done)
                found = 1;
        end
        chk("resume_done", found, 1);
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;

        // clamp
        load(639, 10);
        chk("clamp", tLED, 12'h959);

        // reset mid-run, mid-handshake
        start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("run_busy", busy, 1);
        Time  = 10'd42;
        write = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        chk("rst_outs", {write_ack, tLED, heat, done, busy}, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("rst_ack", write_ack, 1);
        tick();
        chk("rst_load", tLED, 12'h042);
        write = 1'b0;
        tick();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 1) == 0);
            stop  = ($urandom_range(0, 9) == 0);
            write = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0)
                Time = 10'($urandom_range(0, 5));
            else
                Time = 10'($urandom_range(0, 1023));
            DC = 8'($urandom_range(0, 255));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
